// File: rtl/shift_pkg.sv
// Shared types for the sequential right shifter.
//   shift_state_t : FSM encoding (idle / shifting / result held)
//   shift_mode_t  : fill mode latched at accept time
//   SHIFT_STEP_DEFAULT : default per-cycle shift limit
package shift_pkg;

    localparam int SHIFT_STEP_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } shift_state_t;

    typedef enum logic {
        SHIFT_LOGICAL = 1'b0,
        SHIFT_ARITH   = 1'b1
    } shift_mode_t;

endpackage

// File: rtl/shift_right_step.sv
// One bounded right-shift stage: result = data >> amt with `fill` entering
// the vacated MSBs, for amt in 0..STEP.
//   data   : operand
//   amt    : shift amount, 0..STEP (values above STEP pass data through)
//   fill   : bit shifted into the vacated positions
//   result : shifted value
module shift_right_step
    import shift_pkg::*;
#(
    parameter int N    = 32,
    parameter int STEP = SHIFT_STEP_DEFAULT,
    parameter int AW   = $clog2(STEP) + 1
) (
    input  logic [N-1:0]  data,
    input  logic [AW-1:0] amt,
    input  logic          fill,
    output logic [N-1:0]  result
);

    // Sign/zero-extended operand; each candidate is an N-bit window into it.
    logic [N+STEP-1:0]     ext;
    logic [STEP:0][N-1:0]  cand;

    assign ext = {{STEP{fill}}, data};

    for (genvar k = 0; k <= STEP; k++) begin : g_cand
        assign cand[k] = ext[k +: N];
    end

    always_comb begin
        result = data;
        for (int k = 0; k <= STEP; k++) begin
            if (amt == AW'(k)) result = cand[k];
        end
    end

endmodule

// File: rtl/shift_right_sequential.sv
// Multi-cycle logical/arithmetic right shifter, at most STEP bits per clock,
// valid/ready on both sides, one operation in flight.
//   clk, rst            : rising-edge clock, async active-low reset
//   in_valid/in_ready   : operand handshake (in, shamt, arith)
//   out_valid/out_ready : result handshake (out)
// Latency from accept edge to out_valid: 1 + ceil(shamt/STEP) edges.
module shift_right_sequential
    import shift_pkg::*;
#(
    parameter int N    = 32,
    parameter int STEP = SHIFT_STEP_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in,
    input  logic [$clog2(N)-1:0] shamt,
    input  logic                 arith,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out
);

    localparam int SW = $clog2(N);
    localparam int AW = $clog2(STEP) + 1;
    localparam logic [SW:0] STEP_W = (SW+1)'(STEP);

    shift_state_t  state, state_nxt;
    logic [N-1:0]  acc, acc_shifted;
    logic [SW-1:0] rem;
    shift_mode_t   mode;
    logic          sign;

    logic          fill;
    logic          last;
    logic [AW-1:0] step_amt;
    logic          accept;

    // Fill is frozen at accept so later input changes cannot leak in.
    assign fill     = (mode == SHIFT_ARITH) && sign;
    // rem is widened by one bit so STEP == N still compares correctly.
    assign last     = ({1'b0, rem} <= STEP_W);
    assign step_amt = last ? AW'(rem) : AW'(STEP);
    assign accept   = in_valid && in_ready;
    assign out      = acc;

    shift_right_step #(.N(N), .STEP(STEP), .AW(AW)) u_step (
        .data   (acc),
        .amt    (step_amt),
        .fill   (fill),
        .result (acc_shifted)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                // Held low while reset is asserted even though state is IDLE.
                in_ready = rst;
                if (in_valid && rst)
                    state_nxt = (shamt == '0) ? S_DONE : S_SHIFT;
            end
            S_SHIFT: begin
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc  <= '0;
            rem  <= '0;
            mode <= SHIFT_LOGICAL;
            sign <= 1'b0;
        end else if (accept) begin
            acc  <= in;
            rem  <= shamt;
            mode <= shift_mode_t'(arith);
            sign <= in[N-1];
        end else if (state == S_SHIFT) begin
            acc  <= acc_shifted;
            rem  <= rem - SW'(step_amt);
        end
    end

endmodule

// File: doc/shift_right_sequential.md
Name: shift_right_sequential

Overview:
- Multi-cycle right shifter, logical or arithmetic, with valid/ready handshakes on both input and output.
- Each cycle it shifts by at most STEP bits, trading latency for a small per-cycle mux.
- It is the right-direction companion to the combinational left shifter and sits beside it in the ALU shift path.
- Used where a full 32-way right barrel shifter is too costly.

Parameters:
- N, 32: data width. Only 32 is supported and verified.
- STEP, 4: maximum shift applied per cycle. Must be a power of two with 1 ≤ STEP ≤ N.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept an operand.
- in  input  N  value to shift.
- shamt  input  $clog2(N)  shift amount, 0..31.
- arith  input  1  0 = logical (zero fill); 1 = arithmetic (fill with in[N-1]).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out  output  N  shifted result.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, in_ready=0 while rst is low, out_valid=0, out=0, internal accumulator/remaining/mode registers cleared.
- After reset deasserts: in_ready=1 from the first cycle.
- States: IDLE, SHIFT, DONE. Encoding is shared (see Decomposition).
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: acc<=in, rem<=shamt, fill mode latched from arith, sign bit latched from in[N-1].
  - Next state is DONE if shamt==0, otherwise SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each cycle: step=min(rem,STEP); acc<=acc shifted right by step, vacated MSBs take the latched fill bit; rem<=rem-step.
  - Go to DONE when rem≤STEP, i.e. on the last shift.
- DONE:
  - out_valid=1, out=acc, in_ready=0.
  - out and out_valid hold stable until out_ready=1.
  - On out_valid&&out_ready: go to IDLE next cycle and deassert out_valid.
- Latency: 1+ceil(shamt/STEP) clock edges from the accepting edge to out_valid high.
  - shamt=0: 1 edge.
  - shamt=31 with STEP=4: 9 edges.
- Throughput: one operation in flight. No new accept in DONE even when out_ready=1; accept resumes in IDLE the following cycle.
- Fill bit is captured at accept time. Input changes after accept have no effect.
- Arithmetic shift of a negative value by 31 yields all ones. Logical shift by 31 yields in[31] in bit 0.
- out is don't-care outside DONE but must never be X. It is driven from acc.
- Reset mid-operation (SHIFT or DONE): operation discarded, outputs return to reset values, no result emitted.
- shamt is $clog2(N) bits wide, so no out-of-range value exists.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} shift_state_t.
  - Localparam SHIFT_STEP_DEFAULT=4.
  - typedef enum logic {SHIFT_LOGICAL=0, SHIFT_ARITH=1} shift_mode_t.
- Sub-module shift_right_step:
  - Combinational, inputs: data[N-1:0], amt[$clog2(STEP):0], fill.
  - Output: data shifted right by amt (0..STEP) with fill in the vacated bits.
  - Implemented as a mux, consistent with the existing mux-based shifter.
- Top level holds the FSM, rem counter, acc register and fill register.

Test Plan:
- Logical shift: in=0x80000000, shamt=31, arith=0 → out=0x00000001; out_valid rises exactly 9 edges after the accept edge.
- Arithmetic shift: in=0x80000000, shamt=4, arith=1 → out=0xF8000000 after 2 edges. Same with shamt=31 → 0xFFFFFFFF.
- Zero shift: in=0xDEADBEEF, shamt=0, either mode → out=0xDEADBEEF, out_valid 1 edge after accept. Also in=0x7FFFFFFF, shamt=1, arith=1 → 0x3FFFFFFF.
- Backpressure: after completion hold out_ready=0 for 5 cycles → out_valid, out stable, in_ready=0, new in_valid ignored. Raise out_ready → accepted; in_ready=1 on the next cycle.
- Reset mid-SHIFT: start shamt=31, assert rst low 3 cycles after accept → out_valid=0, out=0 immediately. After release a new op 0x0000F000>>12 logical → 0x0000000F with correct latency.
- Random sweep: 1000 random in/shamt/arith with random out_ready stalls → compare against a reference >> / >>> model and the latency formula.
